// File: rtl/apb_mac_txq_pkg13.sv
// Shared constants for the MAC transmit queue: register offsets, CTRL/STATUS
// bit positions and the FIFO entry layout ({last, data}).
package apb_mac_txq_pkg13;

  localparam int DATA_W  = 32;
  localparam int ENTRY_W = DATA_W + 1;

  localparam logic [6:0] ADDR_DATA   = 7'h00;
  localparam logic [6:0] ADDR_LAST   = 7'h04;
  localparam logic [6:0] ADDR_CTRL   = 7'h08;
  localparam logic [6:0] ADDR_STATUS = 7'h0C;
  localparam logic [6:0] ADDR_FRAMES = 7'h10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;

endpackage

// File: rtl/txq_fifo13.sv
// Synchronous DEPTH x ENTRY_W FIFO; the extra pointer bit separates full from empty.
module txq_fifo13
  import apb_mac_txq_pkg13::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [ENTRY_W-1:0] i_din,
  output logic [ENTRY_W-1:0] o_dout,
  output logic               o_full,
  output logic               o_empty,
  output logic [PW-1:0]      o_level
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Flush overrides a same-cycle pop; a push never coincides with flush at the top.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (o_level == PW'(DEPTH));
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/apb_mac_txq13.sv
// APB-fed transmit queue for the MAC: pushes words into a FIFO, drains them as a
// valid/ready stream with a last marker, and stalls APB pushes while full.
module apb_mac_txq13
  import apb_mac_txq_pkg13::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              pclk13,
  input  logic              preset13,
  input  logic              psel13,
  input  logic              penable13,
  input  logic              pwrite13,
  input  logic [6:0]        paddr13,
  input  logic [DATA_W-1:0] pwdata13,
  output logic [DATA_W-1:0] prdata13,
  output logic              pready13,
  output logic [DATA_W-1:0] tx_data13,
  output logic              tx_last13,
  output logic              tx_valid13,
  input  logic              tx_ready13
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [6:0]         w_addr;
  logic               w_unused_addr;
  logic               w_access;
  logic               w_push_addr;
  logic               w_wr_done;
  logic               w_push;
  logic               w_flush;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [PW-1:0]      w_level;
  logic [ENTRY_W-1:0] w_head;
  logic               r_en;
  logic [CNT_W-1:0]   r_frames;

  assign w_addr        = {paddr13[6:2], 2'b00};
  assign w_unused_addr = ^paddr13[1:0];
  assign w_access      = psel13 & penable13;
  assign w_push_addr   = (w_addr == ADDR_DATA) | (w_addr == ADDR_LAST);

  // Registered full only: a pop in the stalled cycle frees the slot for the next one.
  assign pready13  = ~(w_access & pwrite13 & w_push_addr & w_full);
  assign w_wr_done = w_access & pready13 & pwrite13;
  assign w_push    = w_wr_done & w_push_addr;
  assign w_flush   = w_wr_done & (w_addr == ADDR_CTRL) & pwdata13[CTRL_FLUSH_BIT];

  assign tx_valid13             = r_en & ~w_empty;
  assign w_pop                  = tx_valid13 & tx_ready13;
  assign {tx_last13, tx_data13} = w_head;

  txq_fifo13 #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (pclk13),
    .i_rst   (preset13),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   ({(w_addr == ADDR_LAST), pwdata13}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // A FRAMES write beats a same-cycle increment; a flushed pop is not a sent frame.
  always_ff @(posedge pclk13 or posedge preset13) begin
    if (preset13) begin
      r_en     <= 1'b0;
      r_frames <= '0;
    end else begin
      if (w_wr_done && (w_addr == ADDR_CTRL)) r_en <= pwdata13[CTRL_EN_BIT];
      if (w_wr_done && (w_addr == ADDR_FRAMES))
        r_frames <= '0;
      else if (w_pop && tx_last13 && !w_flush)
        r_frames <= r_frames + CNT_W'(1);
    end
  end

  always_comb begin
    prdata13 = '0;
    if (w_access && !pwrite13) begin
      case (w_addr)
        ADDR_CTRL:   prdata13[CTRL_EN_BIT] = r_en;
        ADDR_STATUS: begin
          prdata13[STAT_LEVEL_LSB +: 8] = 8'(w_level);
          prdata13[STAT_EMPTY_BIT]      = w_empty;
          prdata13[STAT_FULL_BIT]       = w_full;
        end
        ADDR_FRAMES: prdata13[CNT_W-1:0] = r_frames;
        default:     prdata13 = '0;
      endcase
    end
  end

endmodule
